// File: rtl/voxel_dma_mc.sv
`timescale 1ns/1ps
// voxel_dma_mc: multi-channel memory-to-memory DMA engine.
// NUM_CH channels share one memory port; one beat (read then write) is
// moved per grant and grants rotate round-robin over the busy channels.
// Done/error events land in a W1C interrupt status register gated by a mask.
module voxel_dma_mc #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_wr_en,
    input  logic              reg_rd_en,
    input  logic [7:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              irq_out,
    output logic [NUM_CH-1:0] busy
);

    localparam int BPW   = DATA_W / 8;
    localparam int OFF_W = $clog2(BPW);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [7:0] A_INT_STATUS = 8'h40;
    localparam logic [7:0] A_INT_MASK   = 8'h41;
    localparam logic [7:0] A_DMA_STATUS = 8'h42;

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR_REQ  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CH_W-1:0]     r_grant;
    logic [CH_W-1:0]     r_last;
    logic [DATA_W-1:0]   r_data;
    logic [31:0]         r_rdata;

    logic [NUM_CH-1:0]   r_int_done;
    logic [NUM_CH-1:0]   r_int_err;
    logic [NUM_CH-1:0]   r_mask_done;
    logic [NUM_CH-1:0]   r_mask_err;

    logic [ADDR_W-1:0]   w_src  [NUM_CH];
    logic [ADDR_W-1:0]   w_dst  [NUM_CH];
    logic [LEN_W-1:0]    w_len  [NUM_CH];
    logic [ADDR_W-1:0]   w_sptr [NUM_CH];
    logic [ADDR_W-1:0]   w_dptr [NUM_CH];
    logic [NUM_CH-1:0]   w_busy;
    logic [NUM_CH-1:0]   w_abort_now;
    logic [NUM_CH-1:0]   w_set_done;
    logic [NUM_CH-1:0]   w_set_err;
    logic [NUM_CH-1:0]   w_arb_req;
    logic [NUM_CH-1:0]   w_w1c_done;
    logic [NUM_CH-1:0]   w_w1c_err;
    logic                w_found;
    logic [CH_W-1:0]     w_pick;
    logic [31:0]         w_int_status;
    logic [31:0]         w_int_mask;
    logic [31:0]         w_rd_mux;
    logic                w_unused;

    // Only the low bits of the write data are meaningful for most registers.
    assign w_unused = ^reg_wdata;

    // Per-channel register set, working pointers and beat counter.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [7:0] BASE = 8'(4 * gi);

            logic [ADDR_W-1:0] r_src;
            logic [ADDR_W-1:0] r_dst;
            logic [LEN_W-1:0]  r_len;
            logic [ADDR_W-1:0] r_sptr;
            logic [ADDR_W-1:0] r_dptr;
            logic [LEN_W-1:0]  r_beats;
            logic              r_busy;
            logic              r_abort_pend;

            logic w_wr_src;
            logic w_wr_dst;
            logic w_wr_len;
            logic w_wr_cmd;
            logic w_start;
            logic w_abort;
            logic w_misalign;
            logic w_granted;
            logic w_beat_done;
            logic w_kill;
            logic w_last;
            logic w_load;

            assign w_wr_src    = reg_wr_en && (reg_addr == BASE);
            assign w_wr_dst    = reg_wr_en && (reg_addr == BASE + 8'd1);
            assign w_wr_len    = reg_wr_en && (reg_addr == BASE + 8'd2);
            assign w_wr_cmd    = reg_wr_en && (reg_addr == BASE + 8'd3);
            assign w_start     = w_wr_cmd && reg_wdata[0];
            assign w_abort     = w_wr_cmd && reg_wdata[1];
            assign w_misalign  = (r_src[OFF_W-1:0] != '0) || (r_dst[OFF_W-1:0] != '0)
                               || (r_len[OFF_W-1:0] != '0);
            // A channel owns the engine from its grant until its write is accepted.
            assign w_granted   = (r_state != ST_ARB) && (r_grant == CH_W'(gi));
            assign w_beat_done = w_granted && (r_state == ST_WR_REQ) && mem_req_ready;
            assign w_kill      = r_abort_pend || (w_abort && r_busy);
            assign w_last      = (r_beats == LEN_W'(1));
            assign w_load      = !r_busy && w_start && !w_abort && !w_misalign
                               && (r_len != '0);

            assign w_set_err[gi]   = (!r_busy && w_start && (w_abort || w_misalign))
                                   || (r_busy && w_abort && !w_granted)
                                   || (w_beat_done && w_kill);
            assign w_set_done[gi]  = (!r_busy && w_start && !w_abort && !w_misalign
                                      && (r_len == '0))
                                   || (w_beat_done && w_last && !w_kill);
            assign w_abort_now[gi] = r_busy && w_abort;

            assign w_src[gi]  = r_src;
            assign w_dst[gi]  = r_dst;
            assign w_len[gi]  = r_len;
            assign w_sptr[gi] = r_sptr;
            assign w_dptr[gi] = r_dptr;
            assign w_busy[gi] = r_busy;

            // Programming registers, start/abort handling and per-beat pointer advance.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_src        <= '0;
                    r_dst        <= '0;
                    r_len        <= '0;
                    r_sptr       <= '0;
                    r_dptr       <= '0;
                    r_beats      <= '0;
                    r_busy       <= 1'b0;
                    r_abort_pend <= 1'b0;
                end else begin
                    if (!r_busy) begin
                        if (w_wr_src) r_src <= reg_wdata[ADDR_W-1:0];
                        if (w_wr_dst) r_dst <= reg_wdata[ADDR_W-1:0];
                        if (w_wr_len) r_len <= reg_wdata[LEN_W-1:0];
                    end
                    if (w_load) begin
                        r_sptr       <= r_src;
                        r_dptr       <= r_dst;
                        r_beats      <= r_len >> OFF_W;
                        r_busy       <= 1'b1;
                        r_abort_pend <= 1'b0;
                    end else if (w_beat_done) begin
                        r_sptr  <= r_sptr + ADDR_W'(BPW);
                        r_dptr  <= r_dptr + ADDR_W'(BPW);
                        r_beats <= r_beats - LEN_W'(1);
                        if (w_last || w_kill) begin
                            r_busy       <= 1'b0;
                            r_abort_pend <= 1'b0;
                        end
                    end else if (w_abort_now[gi]) begin
                        // An in-flight beat is allowed to finish before the channel stops.
                        if (w_granted) r_abort_pend <= 1'b1;
                        else           r_busy       <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Channels being aborted this cycle must not win the next grant.
    assign w_arb_req = w_busy & ~w_abort_now;

    // Round-robin search starting just after the last-granted channel.
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_pick  = r_last;
        v_idx   = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            v_idx = (int'(r_last) + i) % NUM_CH;
            if (!w_found && w_arb_req[v_idx]) begin
                w_found = 1'b1;
                w_pick  = CH_W'(v_idx);
            end
        end
    end

    // Engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ARB;
        else        r_state <= w_state_next;
    end

    // Engine next state and memory request outputs.
    always_comb begin
        w_state_next  = r_state;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (r_state)
            ST_ARB: begin
                if (w_found) w_state_next = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = w_sptr[r_grant];
                if (mem_req_ready) w_state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_rsp_valid) w_state_next = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = w_dptr[r_grant];
                mem_req_wdata = r_data;
                if (mem_req_ready) w_state_next = ST_ARB;
            end
            default: w_state_next = ST_ARB;
        endcase
    end

    // Grant bookkeeping and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
            r_data  <= '0;
        end else begin
            if ((r_state == ST_ARB) && w_found) begin
                r_grant <= w_pick;
                r_last  <= w_pick;
            end
            if ((r_state == ST_RD_WAIT) && mem_rsp_valid) r_data <= mem_rsp_rdata;
        end
    end

    assign w_w1c_done = (reg_wr_en && (reg_addr == A_INT_STATUS)) ? reg_wdata[NUM_CH-1:0] : '0;
    assign w_w1c_err  = (reg_wr_en && (reg_addr == A_INT_STATUS)) ? reg_wdata[8 +: NUM_CH] : '0;

    // Interrupt status (hardware set beats a simultaneous W1C) and mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_done  <= '0;
            r_int_err   <= '0;
            r_mask_done <= '0;
            r_mask_err  <= '0;
        end else begin
            r_int_done <= (r_int_done & ~w_w1c_done) | w_set_done;
            r_int_err  <= (r_int_err  & ~w_w1c_err)  | w_set_err;
            if (reg_wr_en && (reg_addr == A_INT_MASK)) begin
                r_mask_done <= reg_wdata[NUM_CH-1:0];
                r_mask_err  <= reg_wdata[8 +: NUM_CH];
            end
        end
    end

    // Assemble the 32-bit views of status and mask.
    always_comb begin
        w_int_status               = '0;
        w_int_status[NUM_CH-1:0]   = r_int_done;
        w_int_status[8 +: NUM_CH]  = r_int_err;
        w_int_mask                 = '0;
        w_int_mask[NUM_CH-1:0]     = r_mask_done;
        w_int_mask[8 +: NUM_CH]    = r_mask_err;
    end

    // Register read decode; CMD and unmapped addresses read as zero.
    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (reg_addr == 8'(4 * c))     w_rd_mux = 32'(w_src[c]);
            if (reg_addr == 8'(4 * c + 1)) w_rd_mux = 32'(w_dst[c]);
            if (reg_addr == 8'(4 * c + 2)) w_rd_mux = 32'(w_len[c]);
        end
        if (reg_addr == A_INT_STATUS) w_rd_mux = w_int_status;
        if (reg_addr == A_INT_MASK)   w_rd_mux = w_int_mask;
        if (reg_addr == A_DMA_STATUS) w_rd_mux = {21'd0, 3'(r_last), 8'(w_busy)};
    end

    // Registered read data, updated only on a read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_rdata <= '0;
        else if (reg_rd_en) r_rdata <= w_rd_mux;
    end

    assign reg_rdata = r_rdata;
    assign busy      = w_busy;
    assign irq_out   = |(r_int_done & r_mask_done) | |(r_int_err & r_mask_err);

endmodule
